// File: rtl/mux16_rr_scheduler.sv
// mux16_rr_scheduler: round-robin arbiter that drives the select of a 4-bit 16:1 channel mux.
// A grant is held for at most HOLD_BEATS beats and ends early if its request drops.
// Each grant is followed by one turnaround cycle before the next grant can be issued.
// Ports:
//   i_clk        system clock, all state changes on posedge
//   i_reset      synchronous active-high reset
//   i_en         1 = new grants allowed; a grant in progress always completes
//   i_req[15:0]  per-channel request, bit k = mux input k
//   o_s[3:0]     registered mux select
//   o_grant      one-hot copy of the granted channel, 0 when no grant is active
//   o_out_valid  mux output carries the granted channel's data this cycle
//   o_busy       high while a grant is active
//   o_beat_cnt   beats elapsed in the current grant, 0-based
module mux16_rr_scheduler #(
    parameter int unsigned HOLD_BEATS = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [15:0] i_req,
    output logic [3:0]  o_s,
    output logic [15:0] o_grant,
    output logic        o_out_valid,
    output logic        o_busy,
    output logic [3:0]  o_beat_cnt
);

    localparam int unsigned N_CH  = 16;
    localparam int unsigned SEL_W = 4;
    localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(HOLD_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [SEL_W-1:0]  r_s;
    logic [N_CH-1:0]   r_grant;
    logic [SEL_W-1:0]  r_beat_cnt;
    logic [SEL_W-1:0]  r_ptr;

    state_t            w_state_nxt;
    logic [SEL_W-1:0]  w_s_nxt;
    logic [N_CH-1:0]   w_grant_nxt;
    logic [SEL_W-1:0]  w_beat_nxt;
    logic [SEL_W-1:0]  w_ptr_nxt;

    logic [2*N_CH-1:0] w_req_dbl;
    logic [N_CH-1:0]   w_req_rot;
    logic [SEL_W-1:0]  w_off;
    logic [SEL_W-1:0]  w_winner;
    logic              w_any_req;
    logic              w_req_sel;

    // Rotate requests so that bit 0 is the channel at the pointer; the lowest set bit
    // of the rotated vector is the offset of the winner from the pointer.
    assign w_req_dbl = {i_req, i_req} >> r_ptr;
    assign w_req_rot = w_req_dbl[N_CH-1:0];
    assign w_any_req = |i_req;
    assign w_req_sel = i_req[r_s];

    // Priority pick of the first requester at or after the pointer
    always_comb begin
        w_off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
        w_winner = r_ptr + w_off;
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_s        <= '0;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_ptr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_s        <= w_s_nxt;
            r_grant    <= w_grant_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_grant_nxt = r_grant;
        w_beat_nxt  = r_beat_cnt;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                w_beat_nxt  = '0;
                if (i_en && w_any_req) begin
                    w_s_nxt     = w_winner;
                    w_grant_nxt = N_CH'(1) << w_winner;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_req_sel && (r_beat_cnt < LAST_BEAT)) begin
                    w_beat_nxt = r_beat_cnt + SEL_W'(1);
                end else begin
                    // Release: either the request dropped or the final beat was used
                    w_ptr_nxt   = r_s + SEL_W'(1);
                    w_grant_nxt = '0;
                    w_beat_nxt  = '0;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_beat_nxt  = '0;
            end
        endcase
    end

    assign o_s         = r_s;
    assign o_grant     = r_grant;
    assign o_beat_cnt  = r_beat_cnt;
    assign o_busy      = (r_state == ST_GRANT);
    // Valid follows the live request of the granted channel so a dropped request is never flagged
    assign o_out_valid = (r_state == ST_GRANT) && w_req_sel;

endmodule
